// File: rtl/clint_bus_responder.sv
// Core-local interruptor on the CPU data-memory port.
// Holds msip, the free-running 64-bit mtime counter and mtimecmp, and drives
// the machine software (IRQ3) and machine timer (IRQ7) interrupt lines.
// Every accepted access completes with a single-cycle mem_ready pulse one
// cycle after the accept edge, which limits throughput to one access per two cycles.
module clint_bus_responder #(
    parameter int unsigned DIVIDER   = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [15:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        IRQ3,
    output logic        IRQ7
);

    localparam int unsigned      PRE_W    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIVIDER - 1);

    // Word offsets (byte offset >> 2)
    localparam logic [13:0] A_MSIP    = 14'h0000;
    localparam logic [13:0] A_CMP_LO  = 14'h1000;
    localparam logic [13:0] A_CMP_HI  = 14'h1001;
    localparam logic [13:0] A_TIME_LO = 14'h2FFE;
    localparam logic [13:0] A_TIME_HI = 14'h2FFF;

    logic [PRE_W-1:0] prescaler;
    logic             tick;
    logic [63:0]      mtime;
    logic [63:0]      mtime_d;
    logic [63:0]      mtimecmp;
    logic [63:0]      mtimecmp_d;
    logic             msip;

    logic [13:0]      word_addr;
    logic             accept;
    logic             wr_en;
    logic             wr_msip;
    logic             wr_cmp_lo;
    logic             wr_cmp_hi;
    logic             wr_time_lo;
    logic             wr_time_hi;
    logic [31:0]      rd_val;
    logic             unused_addr_bits;

    // Byte-lane merge of write data into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    // mem_ready doubles as the "busy" flag, so a request held through the
    // response cycle is not accepted twice.
    assign accept    = sel & mem_valid & ~mem_ready;
    assign wr_en     = accept & (|mem_wstrb);
    assign word_addr = mem_addr[15:2];

    // Byte-offset bits within a word carry no meaning for this block.
    assign unused_addr_bits = ^mem_addr[1:0];

    assign wr_msip    = wr_en & (word_addr == A_MSIP);
    assign wr_cmp_lo  = wr_en & (word_addr == A_CMP_LO);
    assign wr_cmp_hi  = wr_en & (word_addr == A_CMP_HI);
    assign wr_time_lo = wr_en & (word_addr == A_TIME_LO);
    assign wr_time_hi = wr_en & (word_addr == A_TIME_HI);

    assign tick = (prescaler == PRE_LAST);

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_val = '0;
        case (word_addr)
            A_MSIP:    rd_val = {31'd0, msip};
            A_CMP_LO:  rd_val = mtimecmp[31:0];
            A_CMP_HI:  rd_val = mtimecmp[63:32];
            A_TIME_LO: rd_val = mtime[31:0];
            A_TIME_HI: rd_val = mtime[63:32];
            default:   rd_val = '0;
        endcase
    end

    // Next mtime: a software write to either half wins over the tick for that
    // cycle; the unaddressed half holds. The increment is a full 64-bit add,
    // so the lo->hi carry is never torn.
    always_comb begin
        mtime_d = mtime;
        if (wr_time_lo) begin
            mtime_d = {mtime[63:32], merge_bytes(mtime[31:0], mem_wdata, mem_wstrb)};
        end else if (wr_time_hi) begin
            mtime_d = {merge_bytes(mtime[63:32], mem_wdata, mem_wstrb), mtime[31:0]};
        end else if (tick) begin
            mtime_d = mtime + 64'd1;
        end
    end

    // Next mtimecmp: byte-strobed writes to either half.
    always_comb begin
        mtimecmp_d = mtimecmp;
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp[31:0], mem_wdata, mem_wstrb);
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp[63:32], mem_wdata, mem_wstrb);
        end
    end

    // Prescaler free-runs 0..DIVIDER-1; software writes never restart it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Timer and compare registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mtime    <= '0;
            mtimecmp <= CMP_RESET;
        end else begin
            mtime    <= mtime_d;
            mtimecmp <= mtimecmp_d;
        end
    end

    // Timer interrupt: level compare of the current registers, one cycle lag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            IRQ7 <= 1'b0;
        end else begin
            IRQ7 <= (mtime >= mtimecmp);
        end
    end

    // Software interrupt pending bit; only byte lane 0 bit 0 is implemented.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            msip <= 1'b0;
        end else if (wr_msip && mem_wstrb[0]) begin
            msip <= mem_wdata[0];
        end
    end

    assign IRQ3 = msip;

    // Response: one-cycle ready pulse; read data captured on accept and held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= accept;
            if (accept) begin
                mem_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_clint_bus_responder.sv
// Directed bench for clint_bus_responder (DIVIDER=1). Each bus access pushes
// its expected read data into a scoreboard queue; a monitor pops and compares
// whenever mem_ready is seen. Interrupt lines are checked directly.
module tb_clint_bus_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        IRQ3;
    logic        IRQ7;

    typedef struct {
        string       name;
        bit          chk;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    clint_bus_responder #(
        .DIVIDER   (1),
        .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .IRQ3      (IRQ3),
        .IRQ7      (IRQ7)
    );

    always #5 clk = ~clk;

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready rdata=%h", mem_rdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk) begin
                    n_vec++;
                    if (mem_rdata < mon_e.lo || mem_rdata > mon_e.hi) begin
                        n_err++;
                        $display("FAIL %s got=%h want=%h..%h", mon_e.name, mem_rdata, mon_e.lo, mon_e.hi);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // One access; called at a negedge, returns at the negedge where ready is seen.
    task automatic bus(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d,
                       input string name, input bit chk, input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        bit   got;
        e.name = name;
        e.chk  = chk;
        e.lo   = lo;
        e.hi   = hi;
        sb_q.push_back(e);
        sel       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wstrb = s;
        mem_wdata = d;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_ready) got = 1'b1;
        end
        sel       = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = '0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout got=no_ready want=ready", name);
            void'(sb_q.pop_back());
        end
    endtask

    task automatic rd(input logic [15:0] a, input string name, input logic [31:0] exp);
        bus(a, 4'h0, 32'h0, name, 1'b1, exp, exp);
    endtask

    task automatic rd_rng(input logic [15:0] a, input string name, input logic [31:0] lo, input logic [31:0] hi);
        bus(a, 4'h0, 32'h0, name, 1'b1, lo, hi);
    endtask

    task automatic wr(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
        bus(a, s, d, "wr", 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr_chk(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d,
                          input string name, input logic [31:0] old);
        bus(a, s, d, name, 1'b1, old, old);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k_rise;
        int n_rdy;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq3", {31'd0, IRQ3}, 32'd0);
        check("rst_irq7", {31'd0, IRQ7}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, mem_ready}, 32'd0);
        check("post_rst_irq7", {31'd0, IRQ7}, 32'd0);
        rd(16'h4004, "cmp_hi_rst", 32'hFFFF_FFFF);
        rd(16'h4000, "cmp_lo_rst", 32'hFFFF_FFFF);
        rd_rng(16'hBFF8, "mtime_lo_rst", 32'd0, 32'd32);
        rd(16'hBFFC, "mtime_hi_rst", 32'd0);
        rd(16'h0000, "msip_rst", 32'd0);

        // msip / IRQ3
        wr_chk(16'h0000, 4'hF, 32'd1, "msip_wr1_old", 32'd0);
        check("irq3_set", {31'd0, IRQ3}, 32'd1);
        @(negedge clk);
        check("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        rd(16'h0000, "msip_rd1", 32'd1);
        wr_chk(16'h0000, 4'hF, 32'hFFFF_FFFF, "msip_wr_all_old", 32'd1);
        rd(16'h0000, "msip_upper_zero", 32'd1);
        wr_chk(16'h0000, 4'hF, 32'd0, "msip_wr0_old", 32'd1);
        check("irq3_clr", {31'd0, IRQ3}, 32'd0);
        wr(16'h0000, 4'b1110, 32'hFFFF_FFFF);
        rd(16'h0000, "msip_lane0_off", 32'd0);

        // IRQ7 timing: mtime written to 0 -> IRQ7 rises 21 cycles later
        wr_chk(16'h4004, 4'hF, 32'd0, "cmp_hi_old", 32'hFFFF_FFFF);
        wr_chk(16'h4000, 4'hF, 32'd20, "cmp_lo_old", 32'hFFFF_FFFF);
        wr(16'hBFF8, 4'hF, 32'd0);
        k_rise = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (IRQ7) begin
                k_rise = k;
                break;
            end
        end
        check("irq7_latency", k_rise, 32'd21);
        wr_chk(16'h4000, 4'hF, 32'd100, "cmp_lo_old2", 32'd20);
        @(negedge clk);
        check("irq7_clr", {31'd0, IRQ7}, 32'd0);
        rd(16'hBFF8, "mtime_exact", 32'd23);

        // Carry lo->hi and full 64-bit wrap
        wr(16'hBFFC, 4'hF, 32'd5);
        wr(16'hBFF8, 4'hF, 32'hFFFF_FFFE);
        rd(16'hBFF8, "carry_lo_pre", 32'hFFFF_FFFF);
        rd(16'hBFFC, "carry_hi", 32'd6);
        rd(16'hBFF8, "carry_lo_post", 32'd3);
        wr(16'hBFFC, 4'hF, 32'hFFFF_FFFF);
        wr(16'hBFF8, 4'hF, 32'hFFFF_FFFE);
        rd(16'hBFF8, "wrap_lo_pre", 32'hFFFF_FFFF);
        rd(16'hBFFC, "wrap_hi", 32'd0);

        // Byte-strobed write
        wr_chk(16'h4000, 4'b0010, 32'h0000_AB00, "cmp_lo_old3", 32'd100);
        rd(16'h4000, "cmp_lo_byte1", 32'h0000_AB64);
        rd(16'h4004, "cmp_hi_hold", 32'd0);

        // Unmapped offsets
        rd(16'h1234, "unmapped_rd", 32'd0);
        wr(16'h1234, 4'hF, 32'hDEAD_BEEF);
        rd(16'h1234, "unmapped_after_wr", 32'd0);

        // mem_valid held through the ready cycle: two accepts in four cycles
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            exp_t e;
            e.name = "held_rd";
            e.chk  = 1'b1;
            e.lo   = 32'd0;
            e.hi   = 32'd0;
            sb_q.push_back(e);
        end
        sel = 1'b1; mem_valid = 1'b1; mem_addr = 16'h4004; mem_wstrb = 4'h0;
        n_rdy = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready) n_rdy++;
        end
        sel = 1'b0; mem_valid = 1'b0;
        check("held_valid_accepts", n_rdy, 32'd2);

        // sel=0 with mem_valid=1: ignored
        @(negedge clk);
        sel = 1'b0; mem_valid = 1'b1; mem_addr = 16'h0000; mem_wstrb = 4'hF; mem_wdata = 32'd1;
        n_rdy = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready) n_rdy++;
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        check("sel0_no_ready", n_rdy, 32'd0);
        check("sel0_irq3", {31'd0, IRQ3}, 32'd0);

        // Reset right after an accept: response dropped
        @(negedge clk);
        sel = 1'b1; mem_valid = 1'b1; mem_addr = 16'h0000; mem_wstrb = 4'hF; mem_wdata = 32'd1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(negedge clk);
        check("rst_mid_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_mid_irq3", {31'd0, IRQ3}, 32'd0);
        check("rst_mid_rdata", mem_rdata, 32'd0);

        // Write presented while reset is held: lost
        sel = 1'b1; mem_valid = 1'b1; mem_addr = 16'h0000; mem_wstrb = 4'hF; mem_wdata = 32'd1;
        repeat (2) @(negedge clk);
        sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_hold_irq3", {31'd0, IRQ3}, 32'd0);
        rd(16'h0000, "msip_lost", 32'd0);
        rd(16'h4004, "cmp_hi_rst2", 32'hFFFF_FFFF);
        rd(16'hBFFC, "mtime_hi_rst2", 32'd0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
